// File: rtl/cu_issue_arbiter.sv
// Purpose : round-robin issue arbiter from the collector units into a 2-entry issue FIFO.
// Latency : a bundle accepted at edge t is on out_* after edge t and can pop in cycle t+1.
// Backpr. : in_ready_o grants only while the FIFO holds fewer than 2 entries; pops never create same-cycle space.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid_i/ready_o  per-unit bundle handshake; in_ready_o is one-hot or zero
//   in_wid_i/payload_i  per-unit warp id and opaque bundle, slice i = [(i+1)*W-1 -: W]
//   out_*               FIFO head: valid/ready handshake, warp id, bundle, source unit index
//   issue_cnt_o         bundles popped since reset, wraps at 2^32
module cu_issue_arbiter #(
    parameter int NUM_CU    = 4,
    parameter int DEPTH_CU  = 2,
    parameter int WID_W     = 3,
    parameter int PAYLOAD_W = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CU-1:0]           in_valid_i,
    output logic [NUM_CU-1:0]           in_ready_o,
    input  logic [NUM_CU*WID_W-1:0]     in_wid_i,
    input  logic [NUM_CU*PAYLOAD_W-1:0] in_payload_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [WID_W-1:0]            out_wid_o,
    output logic [PAYLOAD_W-1:0]        out_payload_o,
    output logic [DEPTH_CU-1:0]         out_cu_id_o,
    output logic [31:0]                 issue_cnt_o
);

    // FIFO state
    logic [1:0]           count_q, count_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [DEPTH_CU-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]          issue_cnt_q, issue_cnt_d;

    logic [WID_W-1:0]     ent_wid_q [2];
    logic [WID_W-1:0]     ent_wid_d [2];
    logic [PAYLOAD_W-1:0] ent_pay_q [2];
    logic [PAYLOAD_W-1:0] ent_pay_d [2];
    logic [DEPTH_CU-1:0]  ent_cu_q  [2];
    logic [DEPTH_CU-1:0]  ent_cu_d  [2];

    // Arbitration
    logic                 space;
    logic                 grant_vld;
    logic [DEPTH_CU-1:0]  grant_idx;
    logic [DEPTH_CU-1:0]  scan_idx;
    logic                 push;
    logic                 pop;

    // Space looks only at the registered count, so out_ready_i never reaches in_ready_o.
    assign space = (count_q != 2'd2);

    // Scan starting at rr_ptr; the index wraps naturally since NUM_CU is 2^DEPTH_CU.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (rst_n && space) begin
            for (int i = 0; i < NUM_CU; i++) begin
                scan_idx = rr_ptr_q + DEPTH_CU'(i);
                if (!grant_vld && in_valid_i[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        in_ready_o = '0;
        for (int i = 0; i < NUM_CU; i++) begin
            if (grant_vld && (grant_idx == DEPTH_CU'(i))) begin
                in_ready_o[i] = 1'b1;
            end
        end
    end

    assign push = grant_vld;
    assign pop  = (count_q != 2'd0) && out_ready_i;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rr_ptr_d    = rr_ptr_q;
        issue_cnt_d = issue_cnt_q;
        ent_wid_d   = ent_wid_q;
        ent_pay_d   = ent_pay_q;
        ent_cu_d    = ent_cu_q;

        if (push) begin
            ent_wid_d[wr_ptr_q] = in_wid_i[grant_idx*WID_W +: WID_W];
            ent_pay_d[wr_ptr_q] = in_payload_i[grant_idx*PAYLOAD_W +: PAYLOAD_W];
            ent_cu_d[wr_ptr_q]  = grant_idx;
            wr_ptr_d            = ~wr_ptr_q;
            rr_ptr_d            = grant_idx + DEPTH_CU'(1);
        end

        if (pop) begin
            rd_ptr_d    = ~rd_ptr_q;
            issue_cnt_d = issue_cnt_q + 32'd1;
        end

        // Push and pop together only happen at count 1 (a full FIFO cannot push).
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            rr_ptr_q    <= '0;
            issue_cnt_q <= 32'd0;
            for (int e = 0; e < 2; e++) begin
                ent_wid_q[e] <= '0;
                ent_pay_q[e] <= '0;
                ent_cu_q[e]  <= '0;
            end
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_ptr_q    <= rr_ptr_d;
            issue_cnt_q <= issue_cnt_d;
            for (int e = 0; e < 2; e++) begin
                ent_wid_q[e] <= ent_wid_d[e];
                ent_pay_q[e] <= ent_pay_d[e];
                ent_cu_q[e]  <= ent_cu_d[e];
            end
        end
    end

    // Head fields come straight from storage flops, never from in_*.
    assign out_valid_o   = (count_q != 2'd0);
    assign out_wid_o     = ent_wid_q[rd_ptr_q];
    assign out_payload_o = ent_pay_q[rd_ptr_q];
    assign out_cu_id_o   = ent_cu_q[rd_ptr_q];
    assign issue_cnt_o   = issue_cnt_q;

endmodule

// File: tb/tb_cu_issue_arbiter.sv
// Purpose : self-checking bench for cu_issue_arbiter (queue model + directed literal checks).
// Latency : model compares every negedge against the state committed at the previous posedge.
// Backpr. : out_ready_i driven directly by the directed sequences and a random phase.
module tb_cu_issue_arbiter;

    localparam int NUM_CU    = 4;
    localparam int DEPTH_CU  = 2;
    localparam int WID_W     = 3;
    localparam int PAYLOAD_W = 128;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NUM_CU-1:0]           in_valid_i = '0;
    logic [NUM_CU-1:0]           in_ready_o;
    logic [NUM_CU*WID_W-1:0]     in_wid_i;
    logic [NUM_CU*PAYLOAD_W-1:0] in_payload_i;
    logic                        out_valid_o;
    logic                        out_ready_i = 1'b0;
    logic [WID_W-1:0]            out_wid_o;
    logic [PAYLOAD_W-1:0]        out_payload_o;
    logic [DEPTH_CU-1:0]         out_cu_id_o;
    logic [31:0]                 issue_cnt_o;

    cu_issue_arbiter #(
        .NUM_CU(NUM_CU), .DEPTH_CU(DEPTH_CU), .WID_W(WID_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_wid_i(in_wid_i), .in_payload_i(in_payload_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_wid_o(out_wid_o), .out_payload_o(out_payload_o),
        .out_cu_id_o(out_cu_id_o), .issue_cnt_o(issue_cnt_o)
    );

    always #5 clk = ~clk;

    // Per-unit bundles held by the emulated collector units.
    logic [WID_W-1:0]     lane_wid [NUM_CU];
    logic [PAYLOAD_W-1:0] lane_pay [NUM_CU];

    always_comb begin
        in_wid_i     = '0;
        in_payload_i = '0;
        for (int i = 0; i < NUM_CU; i++) begin
            in_wid_i[i*WID_W +: WID_W]             = lane_wid[i];
            in_payload_i[i*PAYLOAD_W +: PAYLOAD_W] = lane_pay[i];
        end
    end

    int checks = 0;
    int errors = 0;
    int seq    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh(input int k);
        seq++;
        lane_pay[k] = {32'(seq), 32'($urandom), 32'($urandom), 32'($urandom)};
        lane_wid[k] = 3'($urandom);
    endtask

    // Reference model: an ordered queue of accepted bundles, a round-robin start index and a pop count.
    typedef struct {
        logic [WID_W-1:0]     wid;
        logic [PAYLOAD_W-1:0] pay;
        int                   cu;
    } ent_t;

    ent_t        q[$];
    int          m_rr  = 0;
    logic [31:0] m_cnt = 32'd0;
    logic [3:0]  gnt_seen = 4'd0;

    always @(negedge clk) begin : model
        logic [3:0] exp_g;
        int         k;
        ent_t       e;
        gnt_seen = in_ready_o;
        if (!rst_n) begin
            chk("in_ready_in_reset", 128'(in_ready_o), 128'd0);
            q.delete();
            m_rr  = 0;
            m_cnt = 32'd0;
        end else begin
            exp_g = 4'd0;
            k     = -1;
            if (q.size() < 2) begin
                for (int i = 0; i < NUM_CU; i++) begin
                    if (k < 0 && in_valid_i[(m_rr + i) % NUM_CU]) k = (m_rr + i) % NUM_CU;
                end
            end
            if (k >= 0) exp_g[k] = 1'b1;
            chk("in_ready", 128'(in_ready_o), 128'(exp_g));
            chk("out_valid", 128'(out_valid_o), 128'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out_wid", 128'(out_wid_o), 128'(q[0].wid));
                chk("out_payload", out_payload_o, q[0].pay);
                chk("out_cu_id", 128'(out_cu_id_o), 128'(q[0].cu));
            end
            chk("issue_cnt", 128'(issue_cnt_o), 128'(m_cnt));
            if (q.size() != 0 && out_ready_i) begin
                e = q.pop_front();
                m_cnt = m_cnt + 32'd1;
            end
            if (k >= 0) begin
                e.wid = lane_wid[k];
                e.pay = lane_pay[k];
                e.cu  = k;
                q.push_back(e);
                m_rr = (k + 1) % NUM_CU;
            end
        end
    end

    // Advance one clock; units whose bundle was just accepted present a fresh one.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CU; k++) begin
            if (gnt_seen[k]) refresh(k);
        end
    endtask

    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] bp_exp[4] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};

    initial begin
        for (int k = 0; k < NUM_CU; k++) refresh(k);
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid_o), 128'd0);
        chk("rst_out_wid", 128'(out_wid_o), 128'd0);
        chk("rst_out_payload", out_payload_o, 128'd0);
        chk("rst_out_cu_id", 128'(out_cu_id_o), 128'd0);
        chk("rst_issue_cnt", 128'(issue_cnt_o), 128'd0);
        chk("rst_in_ready", 128'(in_ready_o), 128'd0);
        cyc();

        // Single unit
        lane_wid[2] = 3'd5;
        in_valid_i  = 4'b0100;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("single_grant", 128'(in_ready_o), 128'(4'b0100));
        cyc();
        in_valid_i = 4'b0000;
        @(negedge clk);
        chk("single_out_valid", 128'(out_valid_o), 128'd1);
        chk("single_out_wid", 128'(out_wid_o), 128'd5);
        chk("single_out_cu_id", 128'(out_cu_id_o), 128'd2);
        cyc();
        @(negedge clk);
        chk("single_issue_cnt", 128'(issue_cnt_o), 128'd1);
        chk("single_drained", 128'(out_valid_o), 128'd0);

        // Wrap: rr pointer now sits at 3
        cyc();
        in_valid_i = 4'b1001;
        @(negedge clk);
        chk("wrap_first", 128'(in_ready_o), 128'(4'b1000));
        cyc();
        @(negedge clk);
        chk("wrap_second", 128'(in_ready_o), 128'(4'b0001));
        cyc();
        in_valid_i = 4'b0000;
        repeat (2) cyc();

        // Round robin with all units valid
        rst_n = 1'b0;
        cyc();
        rst_n       = 1'b1;
        in_valid_i  = 4'b1111;
        out_ready_i = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", j), 128'(in_ready_o), 128'(4'b0001 << rr_exp[j]));
            if (j > 0) chk($sformatf("rr_head%0d", j), 128'(out_cu_id_o), 128'(rr_exp[j-1]));
            cyc();
        end

        // Backpressure
        in_valid_i = 4'b0000;
        rst_n      = 1'b0;
        cyc();
        rst_n       = 1'b1;
        in_valid_i  = 4'b1111;
        out_ready_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("bp_grant%0d", j), 128'(in_ready_o), 128'(bp_exp[j]));
            if (j > 0) chk($sformatf("bp_head%0d", j), 128'(out_cu_id_o), 128'd0);
            cyc();
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", 128'(in_ready_o), 128'd0);
        chk("bp_release_head", 128'(out_cu_id_o), 128'd0);
        cyc();
        @(negedge clk);
        chk("bp_second_head", 128'(out_cu_id_o), 128'd1);
        chk("bp_next_grant", 128'(in_ready_o), 128'(4'b0100));
        cyc();

        // Random push/pop mix, checked cycle by cycle by the model
        for (int n = 0; n < 100; n++) begin
            in_valid_i  = 4'($urandom);
            out_ready_i = ($urandom_range(0, 3) != 0);
            cyc();
        end

        // Reset with a full FIFO
        in_valid_i  = 4'b1111;
        out_ready_i = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("mid_full_valid", 128'(out_valid_o), 128'd1);
        chk("mid_full_rdy", 128'(in_ready_o), 128'd0);
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", 128'(in_ready_o), 128'd0);
        cyc();
        rst_n      = 1'b1;
        in_valid_i = 4'b0110;
        @(negedge clk);
        chk("post_rst_valid", 128'(out_valid_o), 128'd0);
        chk("post_rst_wid", 128'(out_wid_o), 128'd0);
        chk("post_rst_payload", out_payload_o, 128'd0);
        chk("post_rst_cu_id", 128'(out_cu_id_o), 128'd0);
        chk("post_rst_cnt", 128'(issue_cnt_o), 128'd0);
        chk("post_rst_grant", 128'(in_ready_o), 128'(4'b0010));
        out_ready_i = 1'b1;
        cyc();
        in_valid_i = 4'b0000;
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
